delay_meas_ctrl: RTL

//  Sequencer for the on-chip inverter delay experiment. On a start request it selects one
//  of NUM_CHAINS inverter ring oscillators, enables it, waits a settle window, then counts

---
 rtl/delay_meas_pkg.sv | 30 +++
 rtl/delay_meas_ctrl_edge_sync.sv | 41 ++++
 rtl/delay_meas_ctrl.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/delay_meas_pkg.sv
`default_nettype none
// ============================================================================
// Module      : delay_meas_pkg
// Description : Shared types and constants for the inverter delay measurement
//               sequencer: FSM state encoding, result byte-select codes and
//               status byte bit positions.
// Revision    : 1.0 - initial release
// ============================================================================
package delay_meas_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_GATE   = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  // Result byte-select codes
  localparam logic [1:0] c_BSEL_B0     = 2'd0;
  localparam logic [1:0] c_BSEL_B1     = 2'd1;
  localparam logic [1:0] c_BSEL_B2     = 2'd2;
  localparam logic [1:0] c_BSEL_STATUS = 2'd3;

  // Status byte layout: {ovf, done, busy, pad, osc_sel}
  localparam int c_STAT_OVF  = 7;
  localparam int c_STAT_DONE = 6;
  localparam int c_STAT_BUSY = 5;

endpackage
`default_nettype wire

// File: rtl/delay_meas_ctrl_edge_sync.sv
`default_nettype none
// ============================================================================
// Module      : delay_meas_ctrl_edge_sync
// Description : Brings the asynchronous oscillator output into the clk domain
//               through a 2-FF synchronizer and emits a one-cycle pulse on each
//               rising edge of the synchronized signal.
// Ports       : clk      - system clock
//               rst_n    - asynchronous active-low reset
//               i_async  - raw asynchronous input
//               o_tick   - one-cycle rising-edge pulse
// Revision    : 1.0 - initial release
// ============================================================================
module delay_meas_ctrl_edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic i_async,
  output logic o_tick
);

  logic r_s1;
  logic r_s2;
  logic r_s3;

  // All three flops clear on reset so a high input cannot fake an edge
  // relative to stale history right after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= i_async;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  assign o_tick = r_s2 & ~r_s3;

endmodule
`default_nettype wire

// File: rtl/delay_meas_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : delay_meas_ctrl
// Description : Sequencer for the on-chip inverter delay experiment. A start
//               request selects a ring oscillator, enables it, waits a settle
//               window, then counts oscillator rising edges over a fixed gate
//               window and latches the count for byte-wise readout.
// Ports       : clk          - system clock
//               rst_n        - asynchronous active-low reset
//               i_start      - 1-cycle request, honoured in IDLE/DONE only
//               i_chain_sel  - oscillator index, captured on accepted start
//               i_osc_in     - raw asynchronous oscillator output
//               o_osc_en     - enable to selected oscillator
//               o_osc_sel    - registered chain index to the oscillator mux
//               o_busy       - high in SETTLE and GATE
//               o_done       - high in DONE (result valid)
//               o_ovf        - count saturated during last run
//               i_byte_sel   - 0..2 result bytes, 3 status
//               o_dout       - selected byte
// Revision    : 1.0 - initial release
// ============================================================================
module delay_meas_ctrl
  import delay_meas_pkg::*;
#(
  parameter int unsigned GATE_CYCLES   = 10_000_000,
  parameter int unsigned SETTLE_CYCLES = 16,
  parameter int unsigned CNT_W         = 24,
  parameter int unsigned NUM_CHAINS    = 8,
  parameter int unsigned SEL_W         = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start,
  input  logic [SEL_W-1:0] i_chain_sel,
  input  logic             i_osc_in,
  output logic             o_osc_en,
  output logic [SEL_W-1:0] o_osc_sel,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_ovf,
  input  logic [1:0]       i_byte_sel,
  output logic [7:0]       o_dout
);

  // One down-counter serves both SETTLE and GATE windows.
  localparam int unsigned TMR_MAX = (GATE_CYCLES > SETTLE_CYCLES) ? GATE_CYCLES : SETTLE_CYCLES;
  localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);
  localparam logic [TMR_W-1:0] c_SETTLE_LOAD = TMR_W'(SETTLE_CYCLES - 1);
  localparam logic [TMR_W-1:0] c_GATE_LOAD   = TMR_W'(GATE_CYCLES - 1);

  // The status byte packs the chain index below three flag bits.
  generate
    if ((SEL_W < $clog2(NUM_CHAINS)) || (SEL_W > 5) ||
        (GATE_CYCLES < 1) || (SETTLE_CYCLES < 1)) begin : g_cfg_err
      $error("delay_meas_ctrl: unsupported parameter combination");
    end
  endgenerate

  state_e             r_state;
  state_e             w_state_nxt;
  logic               w_accept;
  logic               w_busy;
  logic               w_done;
  logic               w_tick;
  logic               w_tmr_zero;
  logic               w_count_sat;
  logic [CNT_W-1:0]   w_count_nxt;
  logic [TMR_W-1:0]   r_tmr;
  logic [CNT_W-1:0]   r_count;
  logic [CNT_W-1:0]   r_result;
  logic               r_ovf;
  logic [SEL_W-1:0]   r_sel;
  logic [23:0]        w_res_ext;
  logic [7:0]         w_status;

  delay_meas_ctrl_edge_sync u_edge_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_async (i_osc_in),
    .o_tick  (w_tick)
  );

  assign w_tmr_zero  = (r_tmr == '0);
  assign w_count_sat = &r_count;
  // Saturating increment; also the value latched on the final GATE cycle so
  // a tick there is included in the result.
  assign w_count_nxt = (w_tick && !w_count_sat) ? (r_count + CNT_W'(1)) : r_count;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_busy      = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        w_busy = 1'b1;
        if (w_tmr_zero) w_state_nxt = ST_GATE;
      end
      ST_GATE: begin
        w_busy = 1'b1;
        if (w_tmr_zero) w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        w_done = 1'b1;
        if (i_start) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_SETTLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // ----------------------------------------------------------- datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tmr    <= '0;
      r_count  <= '0;
      r_result <= '0;
      r_ovf    <= 1'b0;
      r_sel    <= '0;
    end else if (w_accept) begin
      r_sel   <= i_chain_sel;
      r_count <= '0;
      r_ovf   <= 1'b0;
      r_tmr   <= c_SETTLE_LOAD;
    end else if (r_state == ST_SETTLE) begin
      r_tmr <= w_tmr_zero ? c_GATE_LOAD : (r_tmr - TMR_W'(1));
    end else if (r_state == ST_GATE) begin
      r_count <= w_count_nxt;
      if (w_tick && w_count_sat) r_ovf <= 1'b1;
      if (w_tmr_zero) r_result <= w_count_nxt;
      else            r_tmr    <= r_tmr - TMR_W'(1);
    end
  end

  // Enable follows the (asynchronously reset) state, so it drops at once
  // when rst_n asserts.
  assign o_osc_en  = w_busy;
  assign o_busy    = w_busy;
  assign o_done    = w_done;
  assign o_ovf     = r_ovf;
  assign o_osc_sel = r_sel;

  // ------------------------------------------------------------ readout
  assign w_res_ext = 24'(r_result);

  always_comb begin
    w_status              = 8'(r_sel);
    w_status[c_STAT_OVF]  = r_ovf;
    w_status[c_STAT_DONE] = w_done;
    w_status[c_STAT_BUSY] = w_busy;
  end

  always_comb begin
    o_dout = 8'h00;
    case (i_byte_sel)
      c_BSEL_B0:     o_dout = w_res_ext[7:0];
      c_BSEL_B1:     o_dout = w_res_ext[15:8];
      c_BSEL_B2:     o_dout = w_res_ext[23:16];
      c_BSEL_STATUS: o_dout = w_status;
      default:       o_dout = 8'h00;
    endcase
  end

endmodule
`default_nettype wire
